// File: rtl/led_flow_ctrl.sv
// Purpose: debounced push-button mode selector driving a 4-LED pattern (all on / flow / blink / all off).
// Latency: key edge -> press pulse after 2 sync + DEB_CYCLES debounce cycles; press pulse -> mode/led change 2 clk.
// Backpressure: none; free-running block with no handshake, every input is sampled each clk.
//
// Ports:
//   clk    in   1  system clock, all state on its rising edge
//   rst_n  in   1  asynchronous active-low reset
//   key_n  in   1  raw mode push-button, active-low, asynchronous and bouncy
//   led    out  4  LED drive, active-low (0 = lit), registered
//   mode   out  2  current mode code, registered: 0 ALL_ON, 1 FLOW, 2 BLINK, 3 ALL_OFF
//
// Build option: define LED_FLOW_PINGPONG_EN to make FLOW bounce 0,1,2,3,2,1,0,...
// instead of wrapping 0,1,2,3,0,...

module led_flow_ctrl #(
    parameter int TICK_DIV   = 12500000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic [3:0] led,
    output logic [1:0] mode
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DONE = DW'(1);

    typedef enum logic [1:0] {
        ALL_ON  = 2'd0,
        FLOW    = 2'd1,
        BLINK   = 2'd2,
        ALL_OFF = 2'd3
    } state_t;

    // key conditioning
    logic          key_s1;
    logic          key_s2;
    logic          deb_key;
    logic          deb_key_d;
    logic [DW-1:0] deb_cnt;
    logic          press;

    // pattern state
    state_t        st;
    state_t        st_nxt;
    logic [PW-1:0] pcnt;
    logic          tick;
    logic [1:0]    pos;
    logic [1:0]    pos_nxt;
    logic          phase;     // blink phase: 0 = LEDs on, 1 = LEDs off
    logic [3:0]    led_nxt;
`ifdef LED_FLOW_PINGPONG_EN
    logic          dir;       // 1 = moving up
    logic          dir_nxt;
`endif

    // Synchroniser and debouncer. Released level is 1, so reset parks
    // everything at 1 and no edge can be seen coming out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            deb_key   <= 1'b1;
            deb_key_d <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            key_s1    <= key_n;
            key_s2    <= key_s1;
            deb_key_d <= deb_key;
            if (key_s2 == deb_key) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DMAX) begin
                // DEB_CYCLES consecutive differing samples seen
                deb_key <= key_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DONE;
            end
        end
    end

    // Falling edge of the debounced key only; release is ignored.
    assign press = deb_key_d & ~deb_key;
    assign tick  = (pcnt == PMAX);

    always_comb begin
        st_nxt = ALL_ON;
        case (st)
            ALL_ON:  st_nxt = FLOW;
            FLOW:    st_nxt = BLINK;
            BLINK:   st_nxt = ALL_OFF;
            ALL_OFF: st_nxt = ALL_ON;
            default: st_nxt = ALL_ON;
        endcase
    end

`ifdef LED_FLOW_PINGPONG_EN
    // Turn around on the endpoints so neither 3 nor 0 is shown twice.
    always_comb begin
        pos_nxt = pos + 2'd1;
        dir_nxt = dir;
        if (dir) begin
            if (pos == 2'd3) begin
                pos_nxt = 2'd2;
                dir_nxt = 1'b0;
            end
        end else begin
            if (pos == 2'd0) begin
                pos_nxt = 2'd1;
                dir_nxt = 1'b1;
            end else begin
                pos_nxt = pos - 2'd1;
            end
        end
    end
`else
    always_comb begin
        pos_nxt = pos + 2'd1;
    end
`endif

    always_comb begin
        led_nxt = 4'b1111;
        case (st)
            ALL_ON:  led_nxt = 4'b0000;
            FLOW:    led_nxt = ~(4'b0001 << pos);
            BLINK:   led_nxt = phase ? 4'b1111 : 4'b0000;
            ALL_OFF: led_nxt = 4'b1111;
            default: led_nxt = 4'b1111;
        endcase
    end

    // Mode FSM, prescaler, pattern position and registered outputs.
    // A press restarts the pattern from its first step and swallows any
    // tick that lands on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= ALL_ON;
            pcnt  <= '0;
            pos   <= 2'd0;
            phase <= 1'b0;
`ifdef LED_FLOW_PINGPONG_EN
            dir   <= 1'b1;
`endif
            led   <= 4'b0000;
            mode  <= 2'd0;
        end else begin
            led  <= led_nxt;
            mode <= st;
            if (press) begin
                st    <= st_nxt;
                pcnt  <= '0;
                pos   <= 2'd0;
                phase <= 1'b0;
`ifdef LED_FLOW_PINGPONG_EN
                dir   <= 1'b1;
`endif
            end else begin
                pcnt <= tick ? '0 : pcnt + PONE;
                if (tick) begin
                    case (st)
                        FLOW: begin
                            pos <= pos_nxt;
`ifdef LED_FLOW_PINGPONG_EN
                            dir <= dir_nxt;
`endif
                        end
                        BLINK:   phase <= ~phase;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with TICK_DIV=4, DEB_CYCLES=3.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-derived step by step in the comments below.

module tb_led_flow_ctrl;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic [3:0] led;
    logic [1:0] mode;

    int checks;
    int errors;

    led_flow_ctrl #(
        .TICK_DIV   (4),
        .DEB_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .led   (led),
        .mode  (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LED_FLOW_PINGPONG_EN
    localparam int NSTEP = 7;
    logic [3:0] flow_seq [NSTEP] = '{4'b1101, 4'b1011, 4'b0111, 4'b1011,
                                     4'b1101, 4'b1110, 4'b1101};
`else
    localparam int NSTEP = 4;
    logic [3:0] flow_seq [NSTEP] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
`endif

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check led on each of the next n falling edges.
    task automatic hold_led(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, {4'h0, led}, {4'h0, exp});
        end
    endtask

    // Press the key and wait for the mode to move. Key first sampled at edge
    // E0, synchronised at E0+1, debounce counts at E0+2..E0+4, pulse sampled
    // at E0+5, registered mode visible after E0+6: the 7th falling edge.
    // Returns on the falling edge right after the state-change edge + 1,
    // and releases the key there.
    task automatic do_press(input string tag, input logic [1:0] exp_mode, input logic [3:0] exp_led);
        logic [1:0] old_mode;
        int n;
        n = 0;
        @(negedge clk);
        old_mode = mode;
        key_n = 1'b0;
        while (mode == old_mode && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 8'(n), 8'd7);
        check({tag, "_mode"}, {6'h0, mode}, {6'h0, exp_mode});
        check({tag, "_led"}, {4'h0, led}, {4'h0, exp_led});
        key_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        key_n  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_led", {4'h0, led}, 8'h00);
        check("rst_mode", {6'h0, mode}, 8'h00);

        // Idle after release: ALL_ON, no mode change
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_led", {4'h0, led}, 8'h00);
            check("idle_mode", {6'h0, mode}, 8'h00);
        end

        // Two-cycle bounce: only two differing samples, below threshold
        key_n = 1'b0;
        repeat (2) @(negedge clk);
        key_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("bounce_mode", {6'h0, mode}, 8'h00);
        end

        // First press -> FLOW. Step every 4 cycles; release gives no press.
        do_press("press1", 2'd1, 4'b1110);
        hold_led("flow_pos0", 4'b1110, 3);
        for (int s = 0; s < NSTEP; s++) begin
            hold_led("flow_step", flow_seq[s], 4);
        end
        check("flow_mode_kept", {6'h0, mode}, 8'h01);

        // Second press -> BLINK, starts lit, toggles every 4 cycles
        do_press("press2", 2'd2, 4'b0000);
        hold_led("blink_on0", 4'b0000, 3);
        hold_led("blink_off", 4'b1111, 4);
        hold_led("blink_on1", 4'b0000, 4);

        // Third press -> ALL_OFF, steady
        do_press("press3", 2'd3, 4'b1111);
        hold_led("all_off", 4'b1111, 12);

        // Fourth press -> ALL_ON. State changed at edge P; prescaler 0 after P,
        // so ticks are sampled at P+4, P+8, P+12. Now between P+1 and P+2.
        do_press("press4", 2'd0, 4'b0000);
        // Release sampled P+2, debounced high at P+6. Re-press sampled first
        // at P+7, so its pulse is sampled at P+12 together with a tick.
        repeat (5) @(negedge clk);
        key_n = 1'b0;
        repeat (6) @(negedge clk);
        check("coinc_pre_mode", {6'h0, mode}, 8'h00);
        @(negedge clk);
        check("coinc_mode", {6'h0, mode}, 8'h01);
        check("coinc_led", {4'h0, led}, 8'h0e);
        key_n = 1'b1;
        // Prescaler restarted at P+12: next step at P+16, visible after P+17
        hold_led("coinc_hold", 4'b1110, 3);
        hold_led("coinc_step", 4'b1101, 1);
        repeat (6) @(negedge clk);
        check("pre_rst_mode", {6'h0, mode}, 8'h01);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_led", {4'h0, led}, 8'h00);
        check("arst_mode", {6'h0, mode}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_led", {4'h0, led}, 8'h00);
            check("post_rst_mode", {6'h0, mode}, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
